// File: rtl/dest_fifo_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : dest_fifo_reader_if
// Brief    : Bundles the two destination-FIFO read ports and the merged
//            output stream of the destination FIFO reader.
// Revision : 1.0 - initial release
// ============================================================================
interface dest_fifo_reader_if #(
    parameter int DATA_WIDTH = 6
);
    // FIFO side
    logic                  empty_fifo_D0;
    logic                  empty_fifo_D1;
    logic [DATA_WIDTH-1:0] data_out_D0;
    logic [DATA_WIDTH-1:0] data_out_D1;
    logic                  D0_pop;
    logic                  D1_pop;
    // Merged output stream
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  src_out;

    // The reader: consumes FIFO flags/data, issues pops, drives the stream
    modport master (
        input  empty_fifo_D0, empty_fifo_D1, data_out_D0, data_out_D1,
        output D0_pop, D1_pop, data_out, valid_out, src_out
    );

    // The environment: FIFOs plus whoever consumes the merged stream
    modport slave (
        output empty_fifo_D0, empty_fifo_D1, data_out_D0, data_out_D1,
        input  D0_pop, D1_pop, data_out, valid_out, src_out
    );
endinterface
`default_nettype wire

// File: rtl/dest_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : dest_fifo_reader
// Brief    : Drains destination FIFOs D0/D1 with round-robin pops, merges
//            the words into one registered stream tagged with the source,
//            checks each word's destination bit and counts words per source.
// Revision : 1.0 - initial release
// ============================================================================
module dest_fifo_reader #(
    parameter int DATA_WIDTH  = 6,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,      // asynchronous, active low
    input  logic                   enable,
    dest_fifo_reader_if.master     bus,
    output logic                   mismatch,
    output logic [COUNT_WIDTH-1:0] cnt_D0,
    output logic [COUNT_WIDTH-1:0] cnt_D1,
    output logic [1:0]             state_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_ERROR  = 2'b10
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    state_t                state;
    state_t                state_next;
    logic                  ptr_d1;      // 0: D0 has priority next, 1: D1
    logic                  rd_pend;     // a pop was issued last edge
    logic                  rd_src;      // source of that pop
    logic                  pop_allowed;
    logic                  pop_d0;
    logic                  pop_d1;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  dest_err;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  valid_reg;
    logic                  src_reg;

    // Pops only while actively enabled; the pointer breaks ties when both
    // FIFOs hold data, otherwise the single non-empty FIFO is taken.
    assign pop_allowed = (state == ST_ACTIVE) && enable;
    assign pop_d0 = pop_allowed && !bus.empty_fifo_D0 && (bus.empty_fifo_D1 || !ptr_d1);
    assign pop_d1 = pop_allowed && !bus.empty_fifo_D1 && (bus.empty_fifo_D0 ||  ptr_d1);

    // The FIFO presents the popped word one cycle after the pop edge
    assign rd_word  = rd_src ? bus.data_out_D1 : bus.data_out_D0;
    assign dest_err = rd_pend && (rd_word[DATA_WIDTH-1] != rd_src);

    assign bus.D0_pop    = pop_d0;
    assign bus.D1_pop    = pop_d1;
    assign bus.data_out  = data_reg;
    assign bus.valid_out = valid_reg;
    assign bus.src_out   = src_reg;
    assign state_out     = state;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a destination error wins over any enable change
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (dest_err)    state_next = ST_ERROR;
                else if (enable) state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (dest_err)     state_next = ST_ERROR;
                else if (!enable) state_next = ST_IDLE;
            end
            ST_ERROR: state_next = ST_ERROR;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Pop bookkeeping: in-flight flag, its source and the round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend <= 1'b0;
            rd_src  <= 1'b0;
            ptr_d1  <= 1'b0;
        end else begin
            rd_pend <= pop_d0 || pop_d1;
            if (pop_d0 || pop_d1) begin
                rd_src <= pop_d1;
                ptr_d1 <= pop_d0;
            end
        end
    end

    // Capture of the in-flight word, destination check and saturating counts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
            src_reg   <= 1'b0;
            mismatch  <= 1'b0;
            cnt_D0    <= '0;
            cnt_D1    <= '0;
        end else begin
            valid_reg <= rd_pend;
            if (rd_pend) begin
                data_reg <= rd_word;
                src_reg  <= rd_src;
                if (dest_err) begin
                    mismatch <= 1'b1;
                end
                if (!rd_src) begin
                    if (cnt_D0 != CNT_MAX) cnt_D0 <= cnt_D0 + CNT_ONE;
                end else begin
                    if (cnt_D1 != CNT_MAX) cnt_D1 <= cnt_D1 + CNT_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dest_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_dest_fifo_reader
// Brief    : Directed self-checking bench for dest_fifo_reader with simple
//            behavioural models of the two destination FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dest_fifo_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       mismatch;
    logic [1:0] cnt_D0;
    logic [1:0] cnt_D1;
    logic [1:0] state_out;

    int n_cmp = 0;
    int n_err = 0;

    // FIFO models: write pointers owned by the stimulus, read pointers by
    // the pop process
    logic [5:0] mem0 [0:63];
    logic [5:0] mem1 [0:63];
    int wr0 = 0;
    int wr1 = 0;
    int rd0 = 0;
    int rd1 = 0;

    dest_fifo_reader_if #(.DATA_WIDTH(6)) bus ();

    dest_fifo_reader #(
        .DATA_WIDTH (6),
        .COUNT_WIDTH(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .bus      (bus),
        .mismatch (mismatch),
        .cnt_D0   (cnt_D0),
        .cnt_D1   (cnt_D1),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    assign bus.empty_fifo_D0 = (wr0 == rd0);
    assign bus.empty_fifo_D1 = (wr1 == rd1);

    // A pop sampled on an edge makes the word visible for the following cycle
    always @(posedge clk) begin
        if (bus.D0_pop) begin
            bus.data_out_D0 <= mem0[rd0];
            rd0 <= rd0 + 1;
        end
        if (bus.D1_pop) begin
            bus.data_out_D1 <= mem1[rd1];
            rd1 <= rd1 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push0(input logic [5:0] v);
        mem0[wr0] = v;
        wr0++;
    endtask

    task automatic push1(input logic [5:0] v);
        mem1[wr1] = v;
        wr1++;
    endtask

    // Reset pulse that also empties both FIFO models; returns once the
    // reader has had one edge to leave IDLE (if enabled)
    task automatic apply_reset();
        reset = 1'b0;
        wr0 = rd0;
        wr1 = rd1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        bus.data_out_D0 = '0;
        bus.data_out_D1 = '0;
        repeat (2) @(negedge clk);

        // ---------------- reset values
        chk("rst_state", state_out, 0);
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_data",  bus.data_out, 0);
        chk("rst_src",   bus.src_out, 0);
        chk("rst_mism",  mismatch, 0);
        chk("rst_cnt0",  cnt_D0, 0);
        chk("rst_cnt1",  cnt_D1, 0);
        chk("rst_pop0",  bus.D0_pop, 0);
        chk("rst_pop1",  bus.D1_pop, 0);

        // ---------------- enabled with both FIFOs empty
        reset  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        chk("s1_state", state_out, 1);
        chk("s1_pop0",  bus.D0_pop, 0);
        chk("s1_pop1",  bus.D1_pop, 0);
        chk("s1_valid", bus.valid_out, 0);
        chk("s1_cnt0",  cnt_D0, 0);

        // ---------------- round robin over both FIFOs
        push0(6'b010000); push0(6'b000011);
        push1(6'b110110); push1(6'b101110);
        #1;
        chk("s2_c0_pop0", bus.D0_pop, 1);
        chk("s2_c0_pop1", bus.D1_pop, 0);
        @(negedge clk);
        chk("s2_c1_pop0",  bus.D0_pop, 0);
        chk("s2_c1_pop1",  bus.D1_pop, 1);
        chk("s2_c1_valid", bus.valid_out, 0);
        @(negedge clk);
        chk("s2_c2_valid", bus.valid_out, 1);
        chk("s2_c2_data",  bus.data_out, 6'b010000);
        chk("s2_c2_src",   bus.src_out, 0);
        chk("s2_c2_pop0",  bus.D0_pop, 1);
        @(negedge clk);
        chk("s2_c3_valid", bus.valid_out, 1);
        chk("s2_c3_data",  bus.data_out, 6'b110110);
        chk("s2_c3_src",   bus.src_out, 1);
        chk("s2_c3_pop0",  bus.D0_pop, 0);
        chk("s2_c3_pop1",  bus.D1_pop, 1);
        @(negedge clk);
        chk("s2_c4_data",  bus.data_out, 6'b000011);
        chk("s2_c4_src",   bus.src_out, 0);
        chk("s2_c4_pop0",  bus.D0_pop, 0);
        chk("s2_c4_pop1",  bus.D1_pop, 0);
        @(negedge clk);
        chk("s2_c5_valid", bus.valid_out, 1);
        chk("s2_c5_data",  bus.data_out, 6'b101110);
        chk("s2_c5_src",   bus.src_out, 1);
        @(negedge clk);
        chk("s2_c6_valid", bus.valid_out, 0);
        chk("s2_c6_hold",  bus.data_out, 6'b101110);
        chk("s2_cnt0",     cnt_D0, 2);
        chk("s2_cnt1",     cnt_D1, 2);
        chk("s2_mism",     mismatch, 0);

        // ---------------- only D1 holds data: back-to-back pops
        apply_reset();
        push1(6'b100001); push1(6'b100010); push1(6'b100011);
        #1;
        chk("s3_c0_pop1", bus.D1_pop, 1);
        chk("s3_c0_pop0", bus.D0_pop, 0);
        @(negedge clk);
        chk("s3_c1_pop1", bus.D1_pop, 1);
        @(negedge clk);
        chk("s3_c2_pop1",  bus.D1_pop, 1);
        chk("s3_c2_valid", bus.valid_out, 1);
        chk("s3_c2_data",  bus.data_out, 6'b100001);
        @(negedge clk);
        chk("s3_c3_pop1",  bus.D1_pop, 0);
        chk("s3_c3_valid", bus.valid_out, 1);
        chk("s3_c3_data",  bus.data_out, 6'b100010);
        @(negedge clk);
        chk("s3_c4_valid", bus.valid_out, 1);
        chk("s3_c4_data",  bus.data_out, 6'b100011);
        chk("s3_cnt1",     cnt_D1, 3);
        @(negedge clk);
        chk("s3_c5_valid", bus.valid_out, 0);

        // ---------------- destination error from D0
        apply_reset();
        push0(6'b110110); push0(6'b000001);
        push1(6'b100000);
        #1;
        chk("s4_c0_pop0", bus.D0_pop, 1);
        @(negedge clk);
        chk("s4_c1_pop1", bus.D1_pop, 1);
        chk("s4_c1_mism", mismatch, 0);
        @(negedge clk);
        chk("s4_c2_mism",  mismatch, 1);
        chk("s4_c2_state", state_out, 2);
        chk("s4_c2_valid", bus.valid_out, 1);
        chk("s4_c2_data",  bus.data_out, 6'b110110);
        chk("s4_c2_src",   bus.src_out, 0);
        chk("s4_c2_pop0",  bus.D0_pop, 0);
        @(negedge clk);
        chk("s4_c3_valid", bus.valid_out, 1);
        chk("s4_c3_data",  bus.data_out, 6'b100000);
        chk("s4_c3_src",   bus.src_out, 1);
        chk("s4_c3_pop0",  bus.D0_pop, 0);
        chk("s4_cnt0",     cnt_D0, 1);
        chk("s4_cnt1",     cnt_D1, 1);
        @(negedge clk);
        chk("s4_c4_valid", bus.valid_out, 0);
        chk("s4_c4_state", state_out, 2);
        chk("s4_c4_mism",  mismatch, 1);
        chk("s4_c4_pop0",  bus.D0_pop, 0);

        // ---------------- enable dropped the cycle after a pop
        apply_reset();
        push0(6'b000101); push0(6'b000110);
        #1;
        chk("s5_c0_pop0", bus.D0_pop, 1);
        @(negedge clk);
        chk("s5_c1_pop0", bus.D0_pop, 1);
        enable = 1'b0;
        #1;
        chk("s5_c1_pop0_off", bus.D0_pop, 0);
        @(negedge clk);
        chk("s5_c2_state", state_out, 0);
        chk("s5_c2_valid", bus.valid_out, 1);
        chk("s5_c2_data",  bus.data_out, 6'b000101);
        chk("s5_c2_pop0",  bus.D0_pop, 0);
        @(negedge clk);
        chk("s5_c3_valid", bus.valid_out, 0);
        chk("s5_c3_pop0",  bus.D0_pop, 0);
        chk("s5_cnt0",     cnt_D0, 1);

        // ---------------- counter saturation with 2-bit counters
        enable = 1'b1;
        apply_reset();
        push0(6'b000001); push0(6'b000010); push0(6'b000011);
        push0(6'b000100); push0(6'b000101);
        repeat (8) @(negedge clk);
        chk("s6_cnt0",  cnt_D0, 3);
        chk("s6_cnt1",  cnt_D1, 0);
        chk("s6_state", state_out, 1);
        chk("s6_data",  bus.data_out, 6'b000101);
        chk("s6_valid", bus.valid_out, 0);

        // ---------------- asynchronous reset mid-transfer
        apply_reset();
        push0(6'b000001); push0(6'b000010); push0(6'b000011);
        push1(6'b100001); push1(6'b100010);
        #1;
        chk("s7_c0_pop0", bus.D0_pop, 1);
        @(negedge clk);
        chk("s7_c1_pop1", bus.D1_pop, 1);
        @(negedge clk);
        chk("s7_c2_pop0", bus.D0_pop, 1);
        chk("s7_c2_data", bus.data_out, 6'b000001);
        @(negedge clk);
        chk("s7_c3_valid", bus.valid_out, 1);
        chk("s7_c3_data",  bus.data_out, 6'b100001);
        chk("s7_c3_pop1",  bus.D1_pop, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("s7_r_valid", bus.valid_out, 0);
        chk("s7_r_data",  bus.data_out, 0);
        chk("s7_r_src",   bus.src_out, 0);
        chk("s7_r_state", state_out, 0);
        chk("s7_r_cnt0",  cnt_D0, 0);
        chk("s7_r_cnt1",  cnt_D1, 0);
        chk("s7_r_pop0",  bus.D0_pop, 0);
        chk("s7_r_pop1",  bus.D1_pop, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("s7_after_pop0",  bus.D0_pop, 1);
        chk("s7_after_pop1",  bus.D1_pop, 0);
        chk("s7_after_valid", bus.valid_out, 0);
        @(negedge clk);
        chk("s7_next_pop1", bus.D1_pop, 1);
        @(negedge clk);
        chk("s7_first_valid", bus.valid_out, 1);
        chk("s7_first_data",  bus.data_out, 6'b000011);
        chk("s7_first_src",   bus.src_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
